// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for the 5-stage RISC-V pipeline. It combines
//   load-use hazards, EX-resolved branch mispredicts and data-memory wait
//   states into enable/nop controls for the PC and the stage registers.
//   It also runs a dmem wait watchdog and keeps saturating stall/flush
//   performance counters.
//
// Ports
//   clk_i, rst_i               clock (rising edge), async active-high reset
//   id_rs*_addr_i/_used_i      source registers of the ID instruction
//   ex_rd_addr_i, ex_mem_read_i destination and load flag of the EX instruction
//   ex_br_mispredict_i         EX branch/jump resolved against the prediction
//   dmem_req_i, dmem_ready_i   MEM stage data-memory handshake
//   cnt_clr_i                  synchronous clear of the perf counters
//   pc_en_o, ifid_en_o         PC / IF-ID load enables
//   ifid_nop_o, idex_nop_o     IF-ID flush, ID-EX bubble
//   exmem_en_o, memwb_nop_o    EX-MEM load enable, MEM-WB bubble
//   mem_timeout_o              sticky watchdog flag
//   stall_cnt_o, flush_cnt_o   saturating performance counters
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_br_mispredict_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic             cnt_clr_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             ifid_nop_o,
    output logic             idex_nop_o,
    output logic             exmem_en_o,
    output logic             memwb_nop_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic freeze, flush, load_use, rs1_hit, rs2_hit;

    // Hazard terms. A frozen pipeline holds EX, so a mispredict seen during
    // a freeze is simply re-observed and flushed once the freeze lifts.
    always_comb begin
        freeze   = dmem_req_i & ~dmem_ready_i;
        flush    = ex_br_mispredict_i & ~freeze;
        rs1_hit  = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
        rs2_hit  = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
        load_use = ex_mem_read_i & (ex_rd_addr_i != 5'd0) & (rs1_hit | rs2_hit)
                   & ~freeze & ~flush;
    end

    always_comb begin
        pc_en_o     = ~freeze & ~load_use;
        ifid_en_o   = ~freeze & ~load_use;
        ifid_nop_o  = flush;
        idex_nop_o  = flush | load_use;
        exmem_en_o  = ~freeze;
        memwb_nop_o = freeze;
    end

    // Watchdog FSM: counts consecutive freeze cycles; the timeout flag only
    // reports, pipeline controls remain driven by freeze alone.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready_i || !dmem_req_i) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                    if (wait_cnt_q + WC_W'(1) == WC_W'(MEM_TIMEOUT)) begin
                        state_d   = TIMEOUT;
                        timeout_d = 1'b1;
                    end
                end
            end
            TIMEOUT: begin
                if (!freeze) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Saturating counters; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_en_o && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != '1)    flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule
